// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - round-robin N:1 stream mux with optional burst lock
// One-beat registered output stage; the grant can be held across a burst until its last beat.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int SELW  = 2,
  parameter int LOCK  = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [(2**SELW)-1:0]        in_valid,
  input  logic [(2**SELW)*WIDTH-1:0]  in_data,
  input  logic [(2**SELW)-1:0]        in_last,
  output logic [(2**SELW)-1:0]        in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_last,
  output logic [SELW-1:0]             out_sel,
  input  logic                        out_ready
);

  localparam int NCH = 2**SELW;

  logic [SELW-1:0]  r_ptr;
  logic             r_lock;
  logic [SELW-1:0]  r_lock_ch;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SELW-1:0]  r_out_sel;

  logic [SELW-1:0]  w_gnt;
  logic             w_gnt_vld;
  logic             w_slot_free;
  logic             w_xfer;
  logic [NCH-1:0]   w_ready;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_gnt_last;

  // Downward scan so the channel closest above r_ptr is the one left standing.
  always_comb begin
    w_gnt     = r_ptr;
    w_gnt_vld = 1'b0;
    if (r_lock) begin
      w_gnt     = r_lock_ch;
      w_gnt_vld = in_valid[r_lock_ch];
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (in_valid[r_ptr + SELW'(k)]) begin
          w_gnt     = r_ptr + SELW'(k);
          w_gnt_vld = 1'b1;
        end
      end
    end
  end

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_xfer      = resetn && w_slot_free && w_gnt_vld;

  always_comb begin
    w_ready = '0;
    if (w_xfer) begin
      w_ready[w_gnt] = 1'b1;
    end
  end

  always_comb begin
    w_gnt_data = in_data[int'(w_gnt) * WIDTH +: WIDTH];
    w_gnt_last = in_last[w_gnt];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
      r_lock      <= 1'b0;
      r_lock_ch   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_last  <= w_gnt_last;
      r_out_sel   <= w_gnt;
      r_ptr       <= w_gnt + SELW'(1);
      if (LOCK != 0) begin
        r_lock    <= !w_gnt_last;
        r_lock_ch <= w_gnt;
      end
    end else if (w_slot_free) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bits per channel.
REQ-002 SHALL have parameter SELW, default 2: select width; channel count NCH = 2**SELW (derived, not overridable).
REQ-003 SHALL have parameter LOCK, default 1: 1 = hold grant until last beat of a burst, 0 = re-arbitrate every beat.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port resetn  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  NCH: per-channel request valid, bit i = channel i.
REQ-007 SHALL have port in_data  input  NCH*WIDTH: channel i data at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_last  input  NCH: per-channel last-beat flag.
REQ-009 SHALL have port in_ready  output  NCH: per-channel accept, combinational.
REQ-010 SHALL have port out_valid  output  1: registered output valid.
REQ-011 SHALL have port out_data  output  WIDTH: registered output data.
REQ-012 SHALL have port out_last  output  1: registered last flag of the held beat.
REQ-013 SHALL have port out_sel  output  SELW: channel index of the held beat.
REQ-014 SHALL have port out_ready  input  1: downstream accept.

Function
REQ-015 SHALL define slot_free = !out_valid || out_ready; a transfer on channel i occurs when in_valid[i] && in_ready[i].
REQ-016 SHALL, when unlocked, grant the first channel with in_valid set, searching upward from pointer ptr and wrapping NCH-1 -> 0.
REQ-017 SHALL, when locked, consider only the locked channel; other channels' in_valid are ignored.
REQ-018 SHALL drive in_ready[g] = slot_free && in_valid[g] for granted channel g only; all other bits 0; at most one bit high per cycle.
REQ-019 SHALL, on a transfer from g, load out_data/out_last/out_sel from channel g and set out_valid = 1 the next cycle (latency 1).
REQ-020 SHALL, on a transfer from g, set ptr = (g+1) mod NCH.
REQ-021 SHALL, when LOCK=1, enter lock on channel g if the transferred beat has in_last=0, and leave lock when a beat with in_last=1 transfers.
REQ-022 SHALL, when LOCK=0, never lock; in_last is passed through only.
REQ-023 SHALL clear out_valid when slot_free and no transfer occurs; output registers otherwise hold.
REQ-024 SHALL hold out_data, out_last and out_sel stable while out_valid && !out_ready.
REQ-025 SHALL accept a new beat in the same cycle out_ready pops the held beat (sustained 1 beat/cycle).
REQ-026 SHALL keep grant, ptr and lock unchanged in cycles with no transfer.
REQ-027 SHALL tolerate a locked channel dropping in_valid mid-burst: lock persists, no other channel is granted.

Reset
REQ-028 SHALL, when resetn=0 at a rising edge, set out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0 and lock=0.
REQ-029 SHALL force in_ready to all-zero while resetn=0.
REQ-030 SHALL discard any in-flight burst or held beat on reset; the next grant after reset starts from channel 0.

Verification
REQ-031 SHALL cover: NCH=4, LOCK=0, all in_valid=1111, in_last=1, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-032 SHALL cover: LOCK=1, ch1 sends 3 beats (last on third) while ch2 valid -> out_sel = 1,1,1,2; in_ready[2]=0 until ch1 last transfers.
REQ-033 SHALL cover: out_valid=1, out_data=0xA5A5A5A5, out_ready=0 for 5 cycles with other channels valid -> out_data stable, in_ready=0000 throughout.
REQ-034 SHALL cover: ptr=3, only ch0 and ch3 valid -> ch3 granted first, then ch0 (wrap).
REQ-035 SHALL cover: resetn=0 asserted mid-burst with LOCK=1 on ch2 -> next cycle out_valid=0, lock cleared; after release with ch0 and ch2 valid, ch0 granted first.
REQ-036 SHALL cover: single channel, in_valid pulses with out_ready=1 -> data appears exactly 1 cycle after transfer, out_valid drops the cycle after pop if no new transfer.
